// File: rtl/ybus_driver_bank.sv
// Bank of NCH registered result channels that drives one channel onto the shared
// tri-state IBUS with per-byte-lane enables. Simultaneous enables raise a sticky contention flag.
module ybus_driver_bank #(
  parameter int W        = 16,
  parameter int NCH      = 2,
  parameter int OE_DELAY = 0,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH*W-1:0] y,
  input  logic [NCH-1:0]   ylatch,
  input  logic [NCH-1:0]   nboe,
  input  logic [W/8-1:0]   lane_en,
  input  logic             clr_err,
  inout  wire  [W-1:0]     ibus,
  output logic [NCH-1:0]   valid,
  output logic             busy,
  output logic             contention,
  output logic [CHW-1:0]   err_ch
);
  localparam int LANES = W / 8;

  logic [W-1:0]     hold_q [NCH];
  logic [NCH-1:0]   valid_q, valid_d;
  logic             cont_q, cont_d;
  logic [CHW-1:0]   err_q, err_d;
  logic [NCH-1:0]   nboe_eff;
  logic [LANES-1:0] lane_eff;

  // Effective bus controls: live inputs, or one register stage when OE_DELAY is set
  generate
    if (OE_DELAY != 0) begin : g_oe_reg
      logic [NCH-1:0]   nboe_q;
      logic [LANES-1:0] lane_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          nboe_q <= '1;
          lane_q <= '0;
        end else begin
          nboe_q <= nboe;
          lane_q <= lane_en;
        end
      end
      assign nboe_eff = nboe_q;
      assign lane_eff = lane_q;
    end else begin : g_oe_live
      assign nboe_eff = nboe;
      assign lane_eff = lane_en;
    end
  endgenerate

  logic [NCH-1:0]   act;
  logic             multi, single;
  logic [CHW-1:0]   low_idx;
  logic [LANES-1:0] drive_lane;
  logic [W-1:0]     sel_data;
  logic             drove;

  assign act    = ~nboe_eff;
  assign multi  = (act & (act - NCH'(1))) != '0;
  assign single = (act != '0) && !multi;

  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (act[i]) low_idx = CHW'(i);
    end
  end

  // Reset gates the drivers directly so the bus floats without waiting for an edge
  assign drive_lane = {LANES{single & ~reset}} & lane_eff;
  assign sel_data   = hold_q[low_idx];
  assign drove      = single && (lane_eff != '0);
  assign busy       = |drive_lane;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign ibus[8*k +: 8] = drive_lane[k] ? sel_data[8*k +: 8] : 8'hzz;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      valid_d[i] = ylatch[i] | (valid_q[i] & ~(drove && (low_idx == CHW'(i))));
    end
    cont_d = cont_q;
    err_d  = err_q;
    if (multi) begin
      cont_d = 1'b1;
      if (!cont_q || clr_err) err_d = low_idx;
    end else if (clr_err) begin
      cont_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
      valid_q <= '0;
      cont_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ylatch[i]) hold_q[i] <= y[i*W +: W];
      end
      valid_q <= valid_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
    end
  end

  assign valid      = valid_q;
  assign contention = cont_q;
  assign err_ch     = err_q;

endmodule

// File: tb/tb_ybus_driver_bank.sv
// Scoreboard bench for ybus_driver_bank: a 16-bit/2-channel live-enable instance and a
// 32-bit/4-channel registered-enable instance share directed and random stimulus.
module tb_ybus_driver_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [31:0]  yA;
  logic [1:0]   ylA, nbA, leA;
  logic         clrA;
  wire  [15:0]  ibusA;
  logic [1:0]   valA;
  logic         busyA, contA;
  logic [0:0]   errA;

  logic [127:0] yB;
  logic [3:0]   ylB, nbB, leB;
  logic         clrB;
  wire  [31:0]  ibusB;
  logic [3:0]   valB;
  logic         busyB, contB;
  logic [1:0]   errB;

  ybus_driver_bank #(.W(16), .NCH(2), .OE_DELAY(0)) dutA (
    .clk(clk), .reset(reset), .y(yA), .ylatch(ylA), .nboe(nbA), .lane_en(leA),
    .clr_err(clrA), .ibus(ibusA), .valid(valA), .busy(busyA), .contention(contA),
    .err_ch(errA));

  ybus_driver_bank #(.W(32), .NCH(4), .OE_DELAY(1)) dutB (
    .clk(clk), .reset(reset), .y(yB), .ylatch(ylB), .nboe(nbB), .lane_en(leB),
    .clr_err(clrB), .ibus(ibusB), .valid(valB), .busy(busyB), .contention(contB),
    .err_ch(errB));

  typedef struct {
    int          inst;
    logic [31:0] ibus;
    logic [31:0] mask;
    logic        busy;
    logic [3:0]  valid;
    logic        cont;
    logic [1:0]  err;
  } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus currently on the pins (s_) and for the next cycle (nx_), per instance
  logic [3:0]  s_yl[2], s_nb[2], s_le[2], nx_yl[2], nx_nb[2], nx_le[2];
  logic        s_clr[2], nx_clr[2];
  logic [31:0] s_y[4], nx_y[4];

  // Reference state
  logic [31:0] m_hold[2][4];
  logic [3:0]  m_val[2], m_rnb[2], m_rle[2];
  logic        m_cont[2];
  logic [1:0]  m_err[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] chmask(input int i);
    return (i != 0) ? 4'hF : 4'h3;
  endfunction

  function automatic logic [3:0] eff_nb(input int i);
    return ((i != 0) ? m_rnb[i] : s_nb[i]) | ~chmask(i);
  endfunction

  function automatic logic [3:0] eff_le(input int i);
    return ((i != 0) ? m_rle[i] : s_le[i]) & chmask(i);
  endfunction

  function automatic int lowest(input logic [3:0] a);
    for (int c = 0; c < 4; c++) if (a[c]) return c;
    return 0;
  endfunction

  task automatic model_step(input int i);
    logic [3:0] act, le;
    int n, lo;
    act = ~eff_nb(i);
    le  = eff_le(i);
    n   = $countones(act);
    lo  = lowest(act);
    if (n == 1 && le != 4'h0) m_val[i][lo] = 1'b0;
    for (int c = 0; c < ((i != 0) ? 4 : 2); c++) begin
      if (s_yl[i][c]) begin
        m_hold[i][c] = (i != 0) ? s_y[c] : {16'h0, s_y[c][15:0]};
        m_val[i][c]  = 1'b1;
      end
    end
    if (n >= 2) begin
      if (!m_cont[i] || s_clr[i]) m_err[i] = 2'(lo);
      m_cont[i] = 1'b1;
    end else if (s_clr[i]) begin
      m_cont[i] = 1'b0;
    end
    m_rnb[i] = s_nb[i] | ~chmask(i);
    m_rle[i] = s_le[i] & chmask(i);
  endtask

  function automatic exp_t expect_now(input int i);
    exp_t e;
    logic [3:0] act, le;
    int lo;
    act = ~eff_nb(i);
    le  = eff_le(i);
    lo  = lowest(act);
    e.inst = i;
    e.ibus = '0;
    e.mask = '0;
    if ($countones(act) == 1) begin
      for (int k = 0; k < 4; k++) begin
        if (le[k]) begin
          e.mask[8*k +: 8] = 8'hFF;
          e.ibus[8*k +: 8] = m_hold[i][lo][8*k +: 8];
        end
      end
    end
    e.busy  = (e.mask != '0);
    e.valid = m_val[i];
    e.cont  = m_cont[i];
    e.err   = m_err[i];
    return e;
  endfunction

  task automatic apply_pins();
    yA   = {s_y[1][15:0], s_y[0][15:0]};
    ylA  = s_yl[0][1:0];
    nbA  = s_nb[0][1:0];
    leA  = s_le[0][1:0];
    clrA = s_clr[0];
    yB   = {s_y[3], s_y[2], s_y[1], s_y[0]};
    ylB  = s_yl[1];
    nbB  = s_nb[1];
    leB  = s_le[1];
    clrB = s_clr[1];
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      nx_yl[i]  = 4'h0;
      nx_nb[i]  = 4'hF;
      nx_le[i]  = 4'h0;
      nx_clr[i] = 1'b0;
    end
  endtask

  task automatic set_both(input logic [3:0] yl, input logic [3:0] nb, input logic [3:0] le,
                          input logic clr);
    for (int i = 0; i < 2; i++) begin
      nx_yl[i]  = yl;
      nx_nb[i]  = nb;
      nx_le[i]  = le;
      nx_clr[i] = clr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    s_yl = nx_yl; s_nb = nx_nb; s_le = nx_le; s_clr = nx_clr; s_y = nx_y;
    apply_pins();
    sbq.push_back(expect_now(0));
    sbq.push_back(expect_now(1));
  endtask

  // Monitor: compares every presented expectation against the DUT at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.inst == 0) begin
          chk("A_ibus",  {16'h0, ibusA} & e.mask, e.ibus);
          chk("A_busy",  32'(busyA), 32'(e.busy));
          chk("A_valid", 32'(valA), 32'(e.valid));
          chk("A_cont",  32'(contA), 32'(e.cont));
          chk("A_errch", 32'(errA), 32'(e.err));
        end else begin
          chk("B_ibus",  ibusB & e.mask, e.ibus);
          chk("B_busy",  32'(busyB), 32'(e.busy));
          chk("B_valid", 32'(valB), 32'(e.valid));
          chk("B_cont",  32'(contB), 32'(e.cont));
          chk("B_errch", 32'(errB), 32'(e.err));
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1;
    set_idle();
    for (int c = 0; c < 4; c++) nx_y[c] = '0;
    s_yl = nx_yl; s_nb = nx_nb; s_le = nx_le; s_clr = nx_clr; s_y = nx_y;
    apply_pins();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) m_hold[i][c] = '0;
      m_val[i]  = '0;
      m_cont[i] = 1'b0;
      m_err[i]  = '0;
      m_rnb[i]  = ~chmask(i) | 4'hF;
      m_rle[i]  = '0;
    end
    #12;
    chk("rst_A_busy", 32'(busyA), 0);
    chk("rst_A_valid", 32'(valA), 0);
    chk("rst_A_cont", 32'(contA), 0);
    chk("rst_B_busy", 32'(busyB), 0);
    chk("rst_B_valid", 32'(valB), 0);
    chk("rst_B_errch", 32'(errB), 0);
    @(negedge clk);
    reset = 1'b0;

    // Capture then drive channel 0 on all lanes
    set_idle(); nx_yl[0] = 4'b0001; nx_yl[1] = 4'b0001; nx_y[0] = 32'h5AA5A55A; tick();
    set_both(4'h0, 4'b1110, 4'b1111, 1'b0); tick(); tick();
    set_idle(); tick();
    // Channel 1 on the upper lane only, then with all lanes disabled
    set_idle(); nx_yl[0] = 4'b0010; nx_yl[1] = 4'b0010; nx_y[1] = 32'h00001234; tick();
    set_both(4'h0, 4'b1101, 4'b0010, 1'b0); tick(); tick();
    set_both(4'h0, 4'b1101, 4'b0000, 1'b0); tick(); tick();
    // Contention, clear, and clear together with fresh contention
    set_both(4'h0, 4'b1100, 4'b1111, 1'b0); tick();
    set_idle(); tick(); tick();
    set_both(4'h0, 4'hF, 4'h0, 1'b1); tick();
    set_idle(); tick(); tick();
    set_both(4'h0, 4'b1100, 4'b0000, 1'b1); tick();
    set_both(4'h0, 4'b1010, 4'b0000, 1'b1); tick();
    set_idle(); tick(); tick();
    set_both(4'h0, 4'hF, 4'h0, 1'b1); tick();
    // Same-cycle capture on the driving channel
    set_idle(); nx_yl[0] = 4'b0001; nx_yl[1] = 4'b0001; nx_y[0] = 32'h00000001; tick();
    set_both(4'b0001, 4'b1110, 4'b1111, 1'b0); nx_y[0] = 32'h00000002; tick();
    set_both(4'h0, 4'b1110, 4'b1111, 1'b0); tick(); tick();
    set_idle(); tick();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      nx_nb[i] = ~(4'b0001 << $urandom_range(0, (i != 0) ? 3 : 1));
        else if (r < 8) nx_nb[i] = 4'hF;
        else            nx_nb[i] = 4'($urandom);
        nx_le[i]  = 4'($urandom);
        nx_yl[i]  = 4'($urandom) & 4'($urandom);
        nx_clr[i] = ($urandom_range(0, 9) == 0);
      end
      for (int c = 0; c < 4; c++) nx_y[c] = $urandom;
      tick();
    end

    // Leave channel 0 driving, then assert reset between clock edges
    set_idle(); nx_yl[0] = 4'b0001; nx_yl[1] = 4'b0001; nx_y[0] = 32'hC3C3_3C3C; tick();
    set_both(4'h0, 4'b1110, 4'b1111, 1'b0); tick(); tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_A_busy", 32'(busyA), 0);
    chk("midrst_A_valid", 32'(valA), 0);
    chk("midrst_A_cont", 32'(contA), 0);
    chk("midrst_B_busy", 32'(busyB), 0);
    chk("midrst_B_valid", 32'(valB), 0);
    chk("midrst_B_cont", 32'(contB), 0);
    chk("midrst_B_errch", 32'(errB), 0);
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
